// File: rtl/multitap_word_entry.sv
// -----------------------------------------------------------------------------
// multitap_word_entry
//
// Phone-style multi-tap entry engine for the Hangman front end. Strobed 4x4
// keypad codes are turned into uppercase ASCII letters: repeated presses of a
// letter key cycle through its letters, a different letter key (or '*')
// commits the pending letter. Committed letters accumulate in a DEPTH-character
// word buffer with backspace ('B'), clear ('0') and whole-word submit ('#').
// 'C' ends the game; everything is then ignored until reset.
//
// Optional feature (compile-time macro MULTITAP_TIMEOUT_EN): an inactivity
// timer that auto-commits the pending letter after TIMEOUT idle cycles.
// Without the macro no timer hardware exists and TIMEOUT is ignored.
//
// Parameters
//   DEPTH    word buffer capacity in characters (>= 1)
//   TIMEOUT  idle cycles before auto-commit (>= 2, macro builds only)
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous active-high reset, wins over strobe_i
//   strobe_i        one-cycle pulse, key_i valid this cycle
//   key_i           {row[3:0], col[3:0]}, each one-hot, R0/C0 = 4'b1000
//   preview_o       ASCII of the pending letter, 0 when nothing pending
//   tap_idx_o       tap position of the pending letter
//   letter_valid_o  one-cycle pulse on every commit
//   letter_o        last committed ASCII letter
//   word_len_o      characters in the live buffer
//   buf_full_o      word_len_o == DEPTH
//   word_valid_o    one-cycle pulse on word submit
//   word_out_o      last submitted word, char0 in [7:0], unused slots 0
//   word_out_len_o  length of word_out_o
//   game_end_o      sticky end-of-game flag
// -----------------------------------------------------------------------------
module multitap_word_entry #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 10_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       strobe_i,
    input  logic [7:0]                 key_i,
    output logic [7:0]                 preview_o,
    output logic [1:0]                 tap_idx_o,
    output logic                       letter_valid_o,
    output logic [7:0]                 letter_o,
    output logic [$clog2(DEPTH+1)-1:0] word_len_o,
    output logic                       buf_full_o,
    output logic                       word_valid_o,
    output logic [8*DEPTH-1:0]         word_out_o,
    output logic [$clog2(DEPTH+1)-1:0] word_out_len_o,
    output logic                       game_end_o
);

    localparam int            LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAP   = 2'd1,
        S_ENDED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        K_NONE   = 3'd0,
        K_LETTER = 3'd1,
        K_SUBMIT = 3'd2,
        K_CLEAR  = 3'd3,
        K_WORD   = 3'd4,
        K_BACK   = 3'd5,
        K_END    = 3'd6
    } kind_e;

    // {valid, index}: index 0 corresponds to the 4'b1000 line.
    function automatic logic [2:0] onehot_pos(input logic [3:0] v);
        logic [2:0] r;
        case (v)
            4'b1000: r = 3'b100;
            4'b0100: r = 3'b101;
            4'b0010: r = 3'b110;
            4'b0001: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // First letter of each letter group; group 0 is key '2', group 7 is key '9'.
    function automatic logic [7:0] letter_base(input logic [2:0] g);
        logic [7:0] r;
        case (g)
            3'd0:    r = 8'h41; // ABC
            3'd1:    r = 8'h44; // DEF
            3'd2:    r = 8'h47; // GHI
            3'd3:    r = 8'h4A; // JKL
            3'd4:    r = 8'h4D; // MNO
            3'd5:    r = 8'h50; // PQRS
            3'd6:    r = 8'h54; // TUV
            3'd7:    r = 8'h57; // WXYZ
            default: r = 8'h41;
        endcase
        return r;
    endfunction

    // Highest tap position: keys 7 and 9 carry four letters, the rest three.
    function automatic logic [1:0] tap_max(input logic [2:0] g);
        return ((g == 3'd5) || (g == 3'd7)) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [7:0] letter_ascii(input logic [2:0] g, input logic [1:0] t);
        return letter_base(g) + {6'd0, t};
    endfunction

    // Registered state and outputs
    state_e             state_q, state_d;
    logic [2:0]         group_q, group_d;
    logic [1:0]         tap_q, tap_d;
    logic [8*DEPTH-1:0] buf_q, buf_d;
    logic [LW-1:0]      len_q, len_d;
    logic [7:0]         preview_q, preview_d;
    logic [7:0]         letter_q, letter_d;
    logic               letter_valid_q, letter_valid_d;
    logic               buf_full_q, buf_full_d;
    logic               word_valid_q, word_valid_d;
    logic [8*DEPTH-1:0] word_out_q, word_out_d;
    logic [LW-1:0]      word_out_len_q, word_out_len_d;
    logic               game_end_q, game_end_d;

    // Decoded key and action strobes
    logic [2:0]         row_pos_s, col_pos_s;
    kind_e              kind_s;
    logic [2:0]         group_s;
    logic [7:0]         pend_char_s;
    logic               do_commit_s, do_submit_s, do_clear_s, do_back_s;
    logic               timer_clr_s, timer_tick_s, timer_exp_s;

    // Classify the raw keypad code into an action and, for letter keys, a group.
    always_comb begin
        row_pos_s = onehot_pos(key_i[7:4]);
        col_pos_s = onehot_pos(key_i[3:0]);
        kind_s    = K_NONE;
        group_s   = 3'd0;
        if (row_pos_s[2] && col_pos_s[2]) begin
            case ({row_pos_s[1:0], col_pos_s[1:0]})
                4'd1:    begin kind_s = K_LETTER; group_s = 3'd0; end // 2
                4'd2:    begin kind_s = K_LETTER; group_s = 3'd1; end // 3
                4'd4:    begin kind_s = K_LETTER; group_s = 3'd2; end // 4
                4'd5:    begin kind_s = K_LETTER; group_s = 3'd3; end // 5
                4'd6:    begin kind_s = K_LETTER; group_s = 3'd4; end // 6
                4'd7:    kind_s = K_BACK;                             // B
                4'd8:    begin kind_s = K_LETTER; group_s = 3'd5; end // 7
                4'd9:    begin kind_s = K_LETTER; group_s = 3'd6; end // 8
                4'd10:   begin kind_s = K_LETTER; group_s = 3'd7; end // 9
                4'd11:   kind_s = K_END;                              // C
                4'd12:   kind_s = K_SUBMIT;                           // *
                4'd13:   kind_s = K_CLEAR;                            // 0
                4'd14:   kind_s = K_WORD;                             // #
                default: kind_s = K_NONE;                             // 1, A, D
            endcase
        end else begin
            kind_s = K_NONE;
        end
    end

    // Next-state logic: pick the actions first, then apply them to the buffer
    // in order (commit before clear/backspace/submit) so '#' sees the letter.
    always_comb begin
        state_d        = state_q;
        group_d        = group_q;
        tap_d          = tap_q;
        buf_d          = buf_q;
        len_d          = len_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        word_valid_d   = 1'b0;
        word_out_d     = word_out_q;
        word_out_len_d = word_out_len_q;
        game_end_d     = game_end_q;
        do_commit_s    = 1'b0;
        do_submit_s    = 1'b0;
        do_clear_s     = 1'b0;
        do_back_s      = 1'b0;
        timer_clr_s    = 1'b0;
        timer_tick_s   = 1'b0;
        pend_char_s    = letter_ascii(group_q, tap_q);

        case (state_q)
            S_IDLE: begin
                if (strobe_i) begin
                    case (kind_s)
                        K_LETTER: begin
                            state_d     = S_TAP;
                            group_d     = group_s;
                            tap_d       = 2'd0;
                            timer_clr_s = 1'b1;
                        end
                        K_CLEAR: do_clear_s  = 1'b1;
                        K_WORD:  do_submit_s = (len_q != {LW{1'b0}});
                        K_BACK:  do_back_s   = (len_q != {LW{1'b0}});
                        K_END: begin
                            state_d    = S_ENDED;
                            game_end_d = 1'b1;
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end

            S_TAP: begin
                if (strobe_i && (kind_s != K_NONE)) begin
                    case (kind_s)
                        K_LETTER: begin
                            timer_clr_s = 1'b1;
                            if (group_s == group_q) begin
                                tap_d = (tap_q == tap_max(group_q)) ? 2'd0 : tap_q + 2'd1;
                            end else begin
                                do_commit_s = 1'b1;
                                group_d     = group_s;
                                tap_d       = 2'd0;
                            end
                        end
                        K_SUBMIT: begin
                            do_commit_s = 1'b1;
                            state_d     = S_IDLE;
                            tap_d       = 2'd0;
                        end
                        K_CLEAR: begin
                            do_clear_s = 1'b1;
                            state_d    = S_IDLE;
                            tap_d      = 2'd0;
                        end
                        K_WORD: begin
                            do_commit_s = 1'b1;
                            do_submit_s = 1'b1;
                            state_d     = S_IDLE;
                            tap_d       = 2'd0;
                        end
                        K_BACK: begin
                            state_d = S_IDLE;
                            tap_d   = 2'd0;
                        end
                        K_END: begin
                            state_d    = S_ENDED;
                            game_end_d = 1'b1;
                            tap_d      = 2'd0;
                        end
                        default: state_d = state_q;
                    endcase
                end else if (timer_exp_s) begin
                    // Inactivity expiry; an accepted strobe this cycle would have won.
                    do_commit_s = 1'b1;
                    state_d     = S_IDLE;
                    tap_d       = 2'd0;
                end else begin
                    timer_tick_s = 1'b1;
                end
            end

            S_ENDED: state_d = S_ENDED;

            default: begin
                state_d = S_IDLE;
                tap_d   = 2'd0;
            end
        endcase

        // Commit: the pulse always fires, the buffer only takes the char if room.
        if (do_commit_s) begin
            letter_d       = pend_char_s;
            letter_valid_d = 1'b1;
            if (len_q != DEPTH_L) begin
                buf_d[8*len_q +: 8] = pend_char_s;
                len_d               = len_q + LW'(1);
            end else begin
                len_d = len_q;
            end
        end else begin
            letter_valid_d = 1'b0;
        end

        if (do_clear_s) begin
            buf_d = {(8*DEPTH){1'b0}};
            len_d = {LW{1'b0}};
        end else if (do_back_s) begin
            buf_d[8*(len_q - LW'(1)) +: 8] = 8'd0;
            len_d                          = len_q - LW'(1);
        end else if (do_submit_s) begin
            word_out_d     = buf_d;
            word_out_len_d = len_d;
            buf_d          = {(8*DEPTH){1'b0}};
            len_d          = {LW{1'b0}};
            word_valid_d   = 1'b1;
        end else begin
            word_valid_d = 1'b0;
        end

        preview_d  = (state_d == S_TAP) ? letter_ascii(group_d, tap_d) : 8'd0;
        buf_full_d = (len_d == DEPTH_L);
    end

    // State and output registers; rst takes priority over any strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            group_q        <= 3'd0;
            tap_q          <= 2'd0;
            buf_q          <= {(8*DEPTH){1'b0}};
            len_q          <= {LW{1'b0}};
            preview_q      <= 8'd0;
            letter_q       <= 8'd0;
            letter_valid_q <= 1'b0;
            buf_full_q     <= 1'b0;
            word_valid_q   <= 1'b0;
            word_out_q     <= {(8*DEPTH){1'b0}};
            word_out_len_q <= {LW{1'b0}};
            game_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            group_q        <= group_d;
            tap_q          <= tap_d;
            buf_q          <= buf_d;
            len_q          <= len_d;
            preview_q      <= preview_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            buf_full_q     <= buf_full_d;
            word_valid_q   <= word_valid_d;
            word_out_q     <= word_out_d;
            word_out_len_q <= word_out_len_d;
            game_end_q     <= game_end_d;
        end
    end

`ifdef MULTITAP_TIMEOUT_EN
    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Idle counter: restarts on an accepted letter key, counts while a letter waits.
    always_comb begin
        if (timer_clr_s) begin
            timer_d = {TW{1'b0}};
        end else if (timer_tick_s) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_exp_s = (timer_q == TMAX);
`else
    logic unused_timer_s;

    // Without the timer a pending letter waits for an explicit key.
    assign timer_exp_s    = 1'b0;
    assign unused_timer_s = timer_clr_s ^ timer_tick_s ^ (TIMEOUT > 0);
`endif

    assign preview_o      = preview_q;
    assign tap_idx_o      = tap_q;
    assign letter_valid_o = letter_valid_q;
    assign letter_o       = letter_q;
    assign word_len_o     = len_q;
    assign buf_full_o     = buf_full_q;
    assign word_valid_o   = word_valid_q;
    assign word_out_o     = word_out_q;
    assign word_out_len_o = word_out_len_q;
    assign game_end_o     = game_end_q;

endmodule

// File: tb/tb_multitap_word_entry.sv
module tb_multitap_word_entry;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;
    localparam int LW      = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_i;
    logic               strobe_i;
    logic [7:0]         key_i;
    logic [7:0]         preview_o;
    logic [1:0]         tap_idx_o;
    logic               letter_valid_o;
    logic [7:0]         letter_o;
    logic [LW-1:0]      word_len_o;
    logic               buf_full_o;
    logic               word_valid_o;
    logic [8*DEPTH-1:0] word_out_o;
    logic [LW-1:0]      word_out_len_o;
    logic               game_end_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multitap_word_entry #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .strobe_i(strobe_i), .key_i(key_i),
        .preview_o(preview_o), .tap_idx_o(tap_idx_o),
        .letter_valid_o(letter_valid_o), .letter_o(letter_o),
        .word_len_o(word_len_o), .buf_full_o(buf_full_o),
        .word_valid_o(word_valid_o), .word_out_o(word_out_o),
        .word_out_len_o(word_out_len_o), .game_end_o(game_end_o)
    );

    string keys_tbl = "123A456B789C*0#D";
    string groups[8] = '{"ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};

    // Keypad code for a key legend character.
    function automatic logic [7:0] enc(input logic [7:0] c);
        logic [3:0] r, cc;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (keys_tbl[i] == c) begin
                r  = 4'b1000 >> (i / 4);
                cc = 4'b1000 >> (i % 4);
                v  = {r, cc};
            end
        end
        return v;
    endfunction

    task automatic press(input logic [7:0] c);
        @(negedge clk);
        strobe_i = 1'b1;
        key_i    = enc(c);
        @(negedge clk);
        strobe_i = 1'b0;
        key_i    = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i    = 1'b1;
        strobe_i = 1'b0;
        key_i    = 8'h00;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // ---------------- reference model (keypad semantics) ----------------
    bit         m_ended, m_pend, m_lv, m_wv;
    int         m_g, m_tap, m_timer;
    logic [7:0] m_letter;
    logic [7:0] m_word[$];
    logic [7:0] m_wout[$];

    task automatic model_reset();
        m_ended = 0; m_pend = 0; m_lv = 0; m_wv = 0;
        m_g = 0; m_tap = 0; m_timer = 0; m_letter = 8'h00;
        m_word.delete(); m_wout.delete();
    endtask

    task automatic model_commit();
        logic [7:0] ch;
        ch = groups[m_g][m_tap];
        m_letter = ch;
        m_lv = 1;
        if (m_word.size() < DEPTH) m_word.push_back(ch);
    endtask

    task automatic model_step(input bit stb, input logic [7:0] k);
        logic [7:0] c;
        c = 8'h00;
        m_lv = 0;
        m_wv = 0;
        for (int i = 0; i < 16; i++) if (enc(keys_tbl[i]) == k) c = keys_tbl[i];
        if (m_ended) return;
        if (stb && c != 8'h00 && c != "1" && c != "A" && c != "D") begin
            if (c >= "2" && c <= "9") begin
                if (m_pend && m_g == int'(c - 8'h32)) begin
                    m_tap = (m_tap + 1) % groups[m_g].len();
                end else begin
                    if (m_pend) model_commit();
                    m_pend = 1;
                    m_g = int'(c - 8'h32);
                    m_tap = 0;
                end
                m_timer = 0;
            end else if (c == "*") begin
                if (m_pend) model_commit();
                m_pend = 0;
            end else if (c == "0") begin
                m_pend = 0;
                m_word.delete();
            end else if (c == "#") begin
                if (m_pend) model_commit();
                m_pend = 0;
                if (m_word.size() > 0) begin
                    m_wout = m_word;
                    m_wv = 1;
                    m_word.delete();
                end
            end else if (c == "B") begin
                if (m_pend) m_pend = 0;
                else if (m_word.size() > 0) void'(m_word.pop_back());
            end else if (c == "C") begin
                m_ended = 1;
                m_pend = 0;
            end
        end else if (m_pend) begin
`ifdef MULTITAP_TIMEOUT_EN
            if (m_timer == TIMEOUT - 1) begin
                model_commit();
                m_pend = 0;
            end else begin
                m_timer++;
            end
`endif
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (preview_o !== 8'h00) begin n_err++; $display("FAIL reset_preview got=%h exp=00", preview_o); end
        n_cmp++; if (tap_idx_o !== 2'd0) begin n_err++; $display("FAIL reset_tap got=%0d exp=0", tap_idx_o); end
        n_cmp++; if ({letter_valid_o, letter_o, word_valid_o, buf_full_o, game_end_o} !== 12'h000) begin
            n_err++; $display("FAIL reset_flags got lv=%b l=%h wv=%b bf=%b ge=%b exp all 0",
                              letter_valid_o, letter_o, word_valid_o, buf_full_o, game_end_o); end
        n_cmp++; if ({word_len_o, word_out_len_o, word_out_o} !== '0) begin
            n_err++; $display("FAIL reset_word got len=%0d olen=%0d out=%h exp 0", word_len_o, word_out_len_o, word_out_o); end
    endtask

    task automatic test_tap_cycle();
        logic [7:0] exp_seq[4] = '{8'h41, 8'h42, 8'h43, 8'h41};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press("2");
            n_cmp++; if (preview_o !== exp_seq[i]) begin n_err++; $display("FAIL tap_preview step=%0d got=%h exp=%h", i, preview_o, exp_seq[i]); end
            n_cmp++; if (tap_idx_o !== 2'(i % 3)) begin n_err++; $display("FAIL tap_idx step=%0d got=%0d exp=%0d", i, tap_idx_o, i % 3); end
        end
        press("*");
        n_cmp++; if (letter_valid_o !== 1'b1 || letter_o !== 8'h41) begin n_err++; $display("FAIL tap_commit got lv=%b l=%h exp lv=1 l=41", letter_valid_o, letter_o); end
        n_cmp++; if (word_len_o !== LW'(1) || preview_o !== 8'h00) begin n_err++; $display("FAIL tap_len got len=%0d prev=%h exp len=1 prev=00", word_len_o, preview_o); end
        @(negedge clk);
        n_cmp++; if (letter_valid_o !== 1'b0) begin n_err++; $display("FAIL tap_pulse_width got lv=%b exp 0", letter_valid_o); end
    endtask

    task automatic test_key_change();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press("7");
            n_cmp++; if (preview_o !== 8'h50 + 8'(i)) begin n_err++; $display("FAIL key7_preview step=%0d got=%h exp=%h", i, preview_o, 8'h50 + 8'(i)); end
        end
        press("9");
        n_cmp++; if (letter_valid_o !== 1'b1 || letter_o !== 8'h53) begin n_err++; $display("FAIL key_change_commit got lv=%b l=%h exp lv=1 l=53", letter_valid_o, letter_o); end
        n_cmp++; if (preview_o !== 8'h57 || tap_idx_o !== 2'd0) begin n_err++; $display("FAIL key_change_new got prev=%h tap=%0d exp prev=57 tap=0", preview_o, tap_idx_o); end
    endtask

    task automatic test_buffer_full();
        do_reset();
        press("4"); press("4"); press("*");
        n_cmp++; if (letter_o !== 8'h48 || buf_full_o !== 1'b0) begin n_err++; $display("FAIL full_h got l=%h bf=%b exp l=48 bf=0", letter_o, buf_full_o); end
        press("4"); press("4"); press("4"); press("*");
        n_cmp++; if (buf_full_o !== 1'b1 || word_len_o !== LW'(2)) begin n_err++; $display("FAIL full_i got bf=%b len=%0d exp bf=1 len=2", buf_full_o, word_len_o); end
        press("5"); press("*");
        n_cmp++; if (letter_valid_o !== 1'b1 || letter_o !== 8'h4A || word_len_o !== LW'(2)) begin
            n_err++; $display("FAIL full_drop got lv=%b l=%h len=%0d exp lv=1 l=4a len=2", letter_valid_o, letter_o, word_len_o); end
        press("#");
        n_cmp++; if (word_valid_o !== 1'b1 || word_out_o[15:0] !== 16'h4948 || word_out_len_o !== LW'(2)) begin
            n_err++; $display("FAIL full_submit got wv=%b out=%h olen=%0d exp wv=1 out=4948 olen=2", word_valid_o, word_out_o, word_out_len_o); end
        n_cmp++; if (word_len_o !== LW'(0) || buf_full_o !== 1'b0 || letter_valid_o !== 1'b0) begin
            n_err++; $display("FAIL full_after got len=%0d bf=%b lv=%b exp 0 0 0", word_len_o, buf_full_o, letter_valid_o); end
        @(negedge clk);
        n_cmp++; if (word_valid_o !== 1'b0) begin n_err++; $display("FAIL word_pulse_width got wv=%b exp 0", word_valid_o); end
        press("2"); press("#");
        n_cmp++; if (letter_valid_o !== 1'b1 || word_valid_o !== 1'b1 || word_out_o !== 16'h0041 || word_out_len_o !== LW'(1)) begin
            n_err++; $display("FAIL hash_pending got lv=%b wv=%b out=%h olen=%0d exp 1 1 0041 1", letter_valid_o, word_valid_o, word_out_o, word_out_len_o); end
    endtask

    task automatic test_backspace_clear();
        do_reset();
        press("2"); press("*"); press("2"); press("2"); press("*");
        press("B");
        n_cmp++; if (word_len_o !== LW'(1) || letter_valid_o !== 1'b0) begin n_err++; $display("FAIL back_len got len=%0d lv=%b exp 1 0", word_len_o, letter_valid_o); end
        press("3"); press("B");
        n_cmp++; if (preview_o !== 8'h00 || word_len_o !== LW'(1) || letter_valid_o !== 1'b0) begin
            n_err++; $display("FAIL back_pending got prev=%h len=%0d lv=%b exp 00 1 0", preview_o, word_len_o, letter_valid_o); end
        press("0");
        n_cmp++; if (word_len_o !== LW'(0) || letter_valid_o !== 1'b0 || word_valid_o !== 1'b0) begin
            n_err++; $display("FAIL clear got len=%0d lv=%b wv=%b exp 0 0 0", word_len_o, letter_valid_o, word_valid_o); end
        press("#");
        n_cmp++; if (word_valid_o !== 1'b0 || word_out_len_o !== LW'(0)) begin n_err++; $display("FAIL empty_hash got wv=%b olen=%0d exp 0 0", word_valid_o, word_out_len_o); end
    endtask

    task automatic test_game_end();
        do_reset();
        press("2"); press("*"); press("#"); press("3");
        press("C");
        n_cmp++; if (game_end_o !== 1'b1 || preview_o !== 8'h00 || letter_valid_o !== 1'b0) begin
            n_err++; $display("FAIL end_flag got ge=%b prev=%h lv=%b exp 1 00 0", game_end_o, preview_o, letter_valid_o); end
        press("2");
        n_cmp++; if (preview_o !== 8'h00 || letter_valid_o !== 1'b0 || game_end_o !== 1'b1) begin
            n_err++; $display("FAIL end_ignore got prev=%h lv=%b ge=%b exp 00 0 1", preview_o, letter_valid_o, game_end_o); end
        do_reset();
        n_cmp++; if ({game_end_o, letter_o, word_out_len_o, word_out_o, preview_o} !== '0) begin
            n_err++; $display("FAIL end_reset got ge=%b l=%h olen=%0d out=%h prev=%h exp all 0", game_end_o, letter_o, word_out_len_o, word_out_o, preview_o); end
    endtask

    task automatic test_timeout();
        int first;
        do_reset();
        press("3");
        first = 0;
`ifdef MULTITAP_TIMEOUT_EN
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (letter_valid_o === 1'b1 && first == 0) begin
                first = i;
                n_cmp++; if (letter_o !== 8'h44) begin n_err++; $display("FAIL timeout_letter got=%h exp=44", letter_o); end
            end
        end
        n_cmp++; if (first != 8) begin n_err++; $display("FAIL timeout_latency got=%0d exp=8 (0 = no pulse)", first); end
        press("3");
        repeat (7) @(negedge clk);
        strobe_i = 1'b1; key_i = enc("3");
        @(negedge clk);
        strobe_i = 1'b0; key_i = 8'h00;
        n_cmp++; if (letter_valid_o !== 1'b0 || preview_o !== 8'h45) begin
            n_err++; $display("FAIL timeout_override got lv=%b prev=%h exp 0 45", letter_valid_o, preview_o); end
`else
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (letter_valid_o === 1'b1) first = i;
        end
        n_cmp++; if (first != 0 || preview_o !== 8'h44) begin
            n_err++; $display("FAIL no_timeout got pulse_at=%0d prev=%h exp 0 44", first, preview_o); end
`endif
        press("B");
    endtask

    task automatic test_back_to_back();
        bit         stb, rst_r;
        logic [7:0] k, last_letter, e_prev;
        logic [8*DEPTH-1:0] e_out;
        int         r, idle;
        do_reset();
        model_reset();
        idle = 0;
        last_letter = "2";
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 99);
            rst_r = (r == 0);
            stb = 0;
            k = 8'h00;
            if (idle > 0) begin
                idle--;
            end else if ($urandom_range(0, 49) == 0) begin
                idle = 10;
            end else if (r >= 40) begin
                stb = 1;
                r = $urandom_range(0, 19);
                if (r < 16) begin
                    k = enc(keys_tbl[r]);
                    if (keys_tbl[r] == "C" && $urandom_range(0, 7) != 0) k = enc("2");
                    if (keys_tbl[r] >= "2" && keys_tbl[r] <= "9") last_letter = keys_tbl[r];
                end else if (r < 18) begin
                    k = enc(last_letter);
                end else begin
                    k = 8'($urandom);
                end
            end
            rst_i = rst_r; strobe_i = stb; key_i = k;
            if (rst_r) model_reset(); else model_step(stb, k);
            @(negedge clk);
            e_prev = m_pend ? groups[m_g][m_tap] : 8'h00;
            e_out = '0;
            for (int i = 0; i < m_wout.size(); i++) e_out[8*i +: 8] = m_wout[i];
            n_cmp++; if (preview_o !== e_prev) begin n_err++; $display("FAIL rnd_preview cyc=%0d got=%h exp=%h", cyc, preview_o, e_prev); end
            n_cmp++; if (tap_idx_o !== (m_pend ? 2'(m_tap) : 2'd0)) begin n_err++; $display("FAIL rnd_tap cyc=%0d got=%0d exp=%0d", cyc, tap_idx_o, m_pend ? m_tap : 0); end
            n_cmp++; if (letter_valid_o !== m_lv) begin n_err++; $display("FAIL rnd_lv cyc=%0d got=%b exp=%b", cyc, letter_valid_o, m_lv); end
            n_cmp++; if (letter_o !== m_letter) begin n_err++; $display("FAIL rnd_letter cyc=%0d got=%h exp=%h", cyc, letter_o, m_letter); end
            n_cmp++; if (word_len_o !== LW'(m_word.size())) begin n_err++; $display("FAIL rnd_len cyc=%0d got=%0d exp=%0d", cyc, word_len_o, m_word.size()); end
            n_cmp++; if (buf_full_o !== (m_word.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full cyc=%0d got=%b", cyc, buf_full_o); end
            n_cmp++; if (word_valid_o !== m_wv) begin n_err++; $display("FAIL rnd_wv cyc=%0d got=%b exp=%b", cyc, word_valid_o, m_wv); end
            n_cmp++; if (word_out_o !== e_out) begin n_err++; $display("FAIL rnd_wout cyc=%0d got=%h exp=%h", cyc, word_out_o, e_out); end
            n_cmp++; if (word_out_len_o !== LW'(m_wout.size())) begin n_err++; $display("FAIL rnd_wolen cyc=%0d got=%0d exp=%0d", cyc, word_out_len_o, m_wout.size()); end
            n_cmp++; if (game_end_o !== m_ended) begin n_err++; $display("FAIL rnd_end cyc=%0d got=%b exp=%b", cyc, game_end_o, m_ended); end
        end
        rst_i = 1'b0; strobe_i = 1'b0; key_i = 8'h00;
    endtask

    initial begin
        rst_i = 1'b1; strobe_i = 1'b0; key_i = 8'h00;
        test_reset();
        test_tap_cycle();
        test_key_change();
        test_buffer_full();
        test_backspace_clear();
        test_game_end();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
